vlsu_cam_alloc: RTL and testbench
=================================

Name: vlsu_cam_alloc

Overview:
- Circular-buffer allocator that sits directly upstream of vlsu_cam_top and is the only agent driving its write port, head_i and enable_i.
- Allocates CAM entries in order at the tail, retires them in order from the head, and holds a per-entry valid vector.
- From the valid vector it generates one comparison-enable mask per search port; a mask can be age-restricted so a search only matches entries older than itself.

Parameters:
- WIDTH, 50, data width of one CAM entry.
- DEPTH, 32, number of entries; must be a power of 2.
- READ, 3, number of CAM search ports.
- ADDRESS, $clog2(DEPTH), entry index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_valid_i  in  1  allocation request.
- alloc_data_i  in  WIDTH  data to store in the allocated entry.
- alloc_ready_o  out  1  allocation accepted when high.
- alloc_idx_o  out  ADDRESS  entry index granted; equals the tail.
- commit_i  in  1  retire the entry at head.
- flush_i  in  1  invalidate all entries.
- search_idx_i  in  READ x ADDRESS  per-port age of the searcher.
- search_age_en_i  in  READ  per-port age-restriction enable.
- head_o  out  ADDRESS  oldest entry; drives CAM head_i.
- count_o  out  ADDRESS+1  number of valid entries.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- cam_write_o  out  1  CAM write_i.
- cam_write_addr_o  out  ADDRESS  CAM write_addr_i.
- cam_write_data_o  out  WIDTH  CAM write_data_i.
- cam_enable_o  out  READ x DEPTH  CAM enable_i.

Behaviour:
- Reset values: head=0, tail=0, count=0, valid=0, cam_write_o=0, cam_write_addr_o=0, cam_write_data_o=0. Hence full_o=0, empty_o=1, alloc_ready_o=1, cam_enable_o=0.
- alloc_ready_o = !full_o, taken from the registered count. accept = alloc_valid_i & alloc_ready_o & !flush_i.
- On accept:
  - valid[tail] <= 1 and tail <= tail+1, wrapping modulo DEPTH.
  - Next cycle: cam_write_o=1, cam_write_addr_o=old tail, cam_write_data_o=alloc_data_i. Write latency is exactly 1 cycle, one write per cycle.
- Commit: ret = commit_i & !empty_o & !flush_i. On ret, valid[head] <= 0 and head <= head+1, wrapping. A commit while empty is ignored and leaves no state change.
- count next = count + accept - ret. Simultaneous accept and ret leaves count unchanged.
- When full, an allocation is refused even if a commit happens in the same cycle.
- Flush has priority over alloc and commit: valid <= 0, head <= tail, count <= 0.
  - A CAM write already registered from the previous cycle still issues.
  - A same-cycle alloc is dropped: no write next cycle.
- rst mid-operation returns all state to reset values on the next edge; any pending CAM write is cancelled.
- cam_enable_o is combinational from the registered valid, head and search inputs. For port r and entry e:
  - search_age_en_i[r]=0: enable = valid[e].
  - search_age_en_i[r]=1: enable = valid[e] & (((e-head) mod DEPTH) < ((search_idx_i[r]-head) mod DEPTH)).
  - Subtraction is in ADDRESS bits and wraps naturally.
  - If search_idx_i[r]==head, the mask is all-zero.
- Valid-bit timing: an entry's valid bit is set in the cycle its CAM write is issued. A search can hit stale CAM contents in that cycle; the consumer must ignore matches in the cycle of cam_write_o to the same address.
- No X may appear on any output after reset.

Decomposition:
- vlsu_cam_pkg holds WIDTH, DEPTH, READ, ADDRESS and typedefs width_t, addr_t, depth_t, read_t, plus count_t = logic [ADDRESS:0].
- One sub-module, vlsu_cam_age_mask: combinational, inputs valid, head, search_idx and age_en, output one depth_t mask. It is instantiated READ times.

Test Plan:
- Reset, then 32 consecutive allocs with data j+1 at j=0..31 -> cam_write_addr_o = 0..31 each 1 cycle later; full_o=1 after the 32nd; alloc_ready_o=0; a 33rd request produces no write.
- Full, commit_i and alloc_valid_i together for 1 cycle -> alloc refused, head_o=1, count_o=31; next cycle alloc is accepted into entry 0 (wrap) with cam_write_addr_o=0.
- head=28 and tail=4 (wrapped), port 0 age_en=1, search_idx=2 -> cam_enable_o[0] bits 28..31,0,1 = 1 and all others 0; port 1 age_en=0 -> bits 28..31,0..3 = 1.
- Commit while empty -> head_o, count_o and the valid vector are unchanged; empty_o stays 1.
- Alloc in cycle N, flush in cycle N+1 with an alloc also requested -> the cycle-N write issues in N+1; no write in N+2; count_o=0 and head_o=tail; cam_enable_o=0.
- rst asserted 1 cycle after an accept -> cam_write_o=0 in the following cycle; all outputs at reset values.

Source files
------------

// File: rtl/vlsu_cam_pkg.sv
// Shared sizing and types for the CAM allocator slice.
package vlsu_cam_pkg;

  localparam int unsigned WIDTH   = 50;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned READ    = 3;
  localparam int unsigned ADDRESS = $clog2(DEPTH);

  typedef logic [WIDTH-1:0]   width_t;
  typedef logic [ADDRESS-1:0] addr_t;
  typedef logic [DEPTH-1:0]   depth_t;
  typedef logic [READ-1:0]    read_t;
  typedef logic [ADDRESS:0]   count_t;

endpackage

// File: rtl/vlsu_cam_age_mask.sv
// Comparison-enable mask for one CAM search port, optionally restricted to
// entries older than the searcher (distance from head, modulo DEPTH).
module vlsu_cam_age_mask
  import vlsu_cam_pkg::*;
(
  input  depth_t valid,
  input  addr_t  head,
  input  addr_t  search_idx,
  input  logic   age_en,
  output depth_t mask
);

  addr_t limit;
  addr_t rel;

  // Age of each entry and of the searcher are measured from head; wrap is free in ADDRESS bits.
  always_comb begin
    limit = search_idx - head;
    rel   = '0;
    mask  = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      rel     = addr_t'(e) - head;
      mask[e] = valid[e] & (~age_en | (rel < limit));
    end
  end

endmodule

// File: rtl/vlsu_cam_alloc.sv
// In-order circular allocator feeding the CAM write port, head and enables.
module vlsu_cam_alloc
  import vlsu_cam_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid_i,
  input  width_t                alloc_data_i,
  output logic                  alloc_ready_o,
  output addr_t                 alloc_idx_o,
  input  logic                  commit_i,
  input  logic                  flush_i,
  input  addr_t  [READ-1:0]     search_idx_i,
  input  read_t                 search_age_en_i,
  output addr_t                 head_o,
  output count_t                count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  cam_write_o,
  output addr_t                 cam_write_addr_o,
  output width_t                cam_write_data_o,
  output depth_t [READ-1:0]     cam_enable_o
);

  addr_t  head;
  addr_t  tail;
  count_t count;
  depth_t valid;
  logic   cam_write;
  addr_t  cam_write_addr;
  width_t cam_write_data;

  logic full;
  logic empty;
  logic accept;
  logic ret;

  // Occupancy flags and handshake qualifiers from registered state.
  always_comb begin
    full   = (count == count_t'(DEPTH));
    empty  = (count == '0);
    accept = alloc_valid_i & ~full & ~flush_i;
    ret    = commit_i & ~empty & ~flush_i;
  end

  // Pointer, occupancy, valid-vector and registered CAM write updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid          <= '0;
      cam_write      <= 1'b0;
      cam_write_addr <= '0;
      cam_write_data <= '0;
    end else begin
      cam_write <= accept;
      if (accept) begin
        cam_write_addr <= tail;
        cam_write_data <= alloc_data_i;
      end

      if (flush_i) begin
        valid <= '0;
        head  <= tail;
        count <= '0;
      end else begin
        // head and tail only coincide when empty or full, so set and clear never hit the same bit
        if (accept) begin
          valid[tail] <= 1'b1;
          tail        <= tail + addr_t'(1);
        end
        if (ret) begin
          valid[head] <= 1'b0;
          head        <= head + addr_t'(1);
        end
        if (accept && !ret) begin
          count <= count + count_t'(1);
        end else if (ret && !accept) begin
          count <= count - count_t'(1);
        end
      end
    end
  end

  for (genvar r = 0; r < READ; r++) begin : g_mask
    vlsu_cam_age_mask u_mask (
      .valid      (valid),
      .head       (head),
      .search_idx (search_idx_i[r]),
      .age_en     (search_age_en_i[r]),
      .mask       (cam_enable_o[r])
    );
  end

  // Output mapping.
  always_comb begin
    alloc_ready_o    = ~full;
    alloc_idx_o      = tail;
    head_o           = head;
    count_o          = count;
    full_o           = full;
    empty_o          = empty;
    cam_write_o      = cam_write;
    cam_write_addr_o = cam_write_addr;
    cam_write_data_o = cam_write_data;
  end

endmodule

// File: tb/tb_vlsu_cam_alloc.sv
// Self-checking bench for vlsu_cam_alloc: occupancy model plus directed literals.
module tb_vlsu_cam_alloc;
  import vlsu_cam_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alloc_valid_i = 1'b0;
  width_t            alloc_data_i = '0;
  logic              alloc_ready_o;
  addr_t             alloc_idx_o;
  logic              commit_i = 1'b0;
  logic              flush_i = 1'b0;
  addr_t [READ-1:0]  search_idx_i = '0;
  read_t             search_age_en_i = '0;
  addr_t             head_o;
  count_t            count_o;
  logic              full_o;
  logic              empty_o;
  logic              cam_write_o;
  addr_t             cam_write_addr_o;
  width_t            cam_write_data_o;
  depth_t [READ-1:0] cam_enable_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  vlsu_cam_alloc dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_data_i     (alloc_data_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_idx_o      (alloc_idx_o),
    .commit_i         (commit_i),
    .flush_i          (flush_i),
    .search_idx_i     (search_idx_i),
    .search_age_en_i  (search_age_en_i),
    .head_o           (head_o),
    .count_o          (count_o),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .cam_write_o      (cam_write_o),
    .cam_write_addr_o (cam_write_addr_o),
    .cam_write_data_o (cam_write_data_o),
    .cam_enable_o     (cam_enable_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue described only by head and occupancy; an entry is valid
  // when its distance from head is below the occupancy.
  int          m_head  = 0;
  int          m_count = 0;
  bit          m_wr    = 0;
  int          m_waddr = 0;
  logic [63:0] m_wdata = '0;

  always @(posedge clk) begin
    int  tail;
    bit  acc;
    bit  rt;
    if (rst) begin
      m_head = 0; m_count = 0; m_wr = 0; m_waddr = 0; m_wdata = '0;
    end else begin
      tail = (m_head + m_count) % DEPTH;
      acc  = alloc_valid_i && (m_count < DEPTH) && !flush_i;
      rt   = commit_i && (m_count > 0) && !flush_i;
      m_wr = acc;
      if (acc) begin
        m_waddr = tail;
        m_wdata = 64'(alloc_data_i);
      end
      if (flush_i) begin
        m_head  = tail;
        m_count = 0;
      end else begin
        if (rt) m_head = (m_head + 1) % DEPTH;
        m_count = m_count + int'(acc) - int'(rt);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp_en;
    int          rel_e;
    int          rel_s;
    if (chk_en) begin
      chk("head", 64'(head_o), 64'(m_head));
      chk("count", 64'(count_o), 64'(m_count));
      chk("full", 64'(full_o), 64'(m_count == DEPTH));
      chk("empty", 64'(empty_o), 64'(m_count == 0));
      chk("ready", 64'(alloc_ready_o), 64'(m_count != DEPTH));
      chk("alloc_idx", 64'(alloc_idx_o), 64'((m_head + m_count) % DEPTH));
      chk("cam_write", 64'(cam_write_o), 64'(m_wr));
      chk("cam_addr", 64'(cam_write_addr_o), 64'(m_waddr));
      chk("cam_data", 64'(cam_write_data_o), m_wdata);
      for (int r = 0; r < READ; r++) begin
        exp_en = '0;
        rel_s  = (int'(search_idx_i[r]) - m_head + DEPTH) % DEPTH;
        for (int e = 0; e < DEPTH; e++) begin
          rel_e = (e - m_head + DEPTH) % DEPTH;
          exp_en[e] = (rel_e < m_count) && (!search_age_en_i[r] || rel_e < rel_s);
        end
        chk($sformatf("enable%0d", r), 64'(cam_enable_o[r]), exp_en);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk_en = 1;
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_write", 64'(cam_write_o), 64'd0);
    chk("rst_enable0", 64'(cam_enable_o[0]), 64'd0);

    // Fill all 32 entries.
    for (int j = 0; j < 32; j++) begin
      alloc_valid_i = 1'b1;
      alloc_data_i  = width_t'(j + 1);
      step();
      chk("fill_write", 64'(cam_write_o), 64'd1);
      chk("fill_addr", 64'(cam_write_addr_o), 64'(j));
      chk("fill_data", 64'(cam_write_data_o), 64'(j + 1));
    end
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_ready", 64'(alloc_ready_o), 64'd0);
    alloc_data_i = width_t'(99);
    step();
    chk("over_write", 64'(cam_write_o), 64'd0);
    chk("over_count", 64'(count_o), 64'd32);

    // Full with simultaneous commit: alloc refused.
    commit_i = 1'b1;
    alloc_data_i = width_t'(16'h77);
    step();
    chk("fc_head", 64'(head_o), 64'd1);
    chk("fc_count", 64'(count_o), 64'd31);
    chk("fc_write", 64'(cam_write_o), 64'd0);
    commit_i = 1'b0;
    alloc_data_i = width_t'(16'h123);
    step();
    chk("wrap_write", 64'(cam_write_o), 64'd1);
    chk("wrap_addr", 64'(cam_write_addr_o), 64'd0);
    chk("wrap_data", 64'(cam_write_data_o), 64'h123);
    chk("wrap_count", 64'(count_o), 64'd32);
    alloc_valid_i = 1'b0;

    // Move to head=28, tail=4.
    commit_i = 1'b1;
    repeat (27) step();
    commit_i = 1'b0;
    alloc_valid_i = 1'b1;
    repeat (3) step();
    alloc_valid_i = 1'b0;
    search_idx_i[0] = addr_t'(2);  search_age_en_i[0] = 1'b1;
    search_idx_i[1] = addr_t'(9);  search_age_en_i[1] = 1'b0;
    search_idx_i[2] = addr_t'(28); search_age_en_i[2] = 1'b1;
    #1;
    chk("age_head", 64'(head_o), 64'd28);
    chk("age_idx", 64'(alloc_idx_o), 64'd4);
    chk("age_en0", 64'(cam_enable_o[0]), 64'hF000_0003);
    chk("age_en1", 64'(cam_enable_o[1]), 64'hF000_000F);
    chk("age_en2", 64'(cam_enable_o[2]), 64'd0);
    step();

    // Drain, then commit while empty.
    commit_i = 1'b1;
    repeat (8) step();
    chk("drain_empty", 64'(empty_o), 64'd1);
    step();
    commit_i = 1'b0;
    chk("ce_head", 64'(head_o), 64'd4);
    chk("ce_count", 64'(count_o), 64'd0);
    chk("ce_empty", 64'(empty_o), 64'd1);
    chk("ce_en1", 64'(cam_enable_o[1]), 64'd0);

    // Alloc then flush with a dropped alloc.
    search_age_en_i = '0;
    alloc_valid_i = 1'b1;
    alloc_data_i  = width_t'(16'hAAA);
    step();
    chk("fl_write1", 64'(cam_write_o), 64'd1);
    chk("fl_addr1", 64'(cam_write_addr_o), 64'd4);
    flush_i = 1'b1;
    alloc_data_i = width_t'(16'hBBB);
    step();
    flush_i = 1'b0;
    alloc_valid_i = 1'b0;
    chk("fl_write2", 64'(cam_write_o), 64'd0);
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_head", 64'(head_o), 64'd5);
    chk("fl_tail", 64'(alloc_idx_o), 64'd5);
    chk("fl_en0", 64'(cam_enable_o[0]), 64'd0);

    // Reset right after an accept cancels the pending write.
    alloc_valid_i = 1'b1;
    alloc_data_i  = width_t'(16'hCCC);
    step();
    alloc_valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_write", 64'(cam_write_o), 64'd0);
    chk("rr_head", 64'(head_o), 64'd0);
    chk("rr_count", 64'(count_o), 64'd0);
    chk("rr_addr", 64'(cam_write_addr_o), 64'd0);
    chk("rr_data", 64'(cam_write_data_o), 64'd0);

    // Mixed traffic against the model.
    for (int i = 0; i < 150; i++) begin
      alloc_valid_i   = ($urandom_range(0, 3) != 0);
      alloc_data_i    = width_t'({$urandom(), $urandom()});
      commit_i        = ($urandom_range(0, 1) != 0);
      flush_i         = ($urandom_range(0, 19) == 0);
      search_age_en_i = read_t'($urandom());
      for (int r = 0; r < READ; r++) search_idx_i[r] = addr_t'($urandom());
      step();
    end
    alloc_valid_i = 1'b0;
    commit_i = 1'b0;
    flush_i = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
